// File: rtl/uart_pkg.sv
// Shared types and helpers for the block UART receiver: parity modes, receiver FSM states,
// baud divisor and 3-sample majority vote.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_block_rx_if.sv
// Block output channel: assembled block with valid/ready; master drives block and valid,
// slave drives ready.
interface uart_block_rx_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] block_out;
  logic             block_valid;
  logic             block_ready;

  modport master (
    output block_out,
    output block_valid,
    input  block_ready
  );

  modport slave (
    input  block_out,
    input  block_valid,
    output block_ready
  );

endinterface

// File: rtl/uart_rx_char.sv
// Single-character UART receiver: 2-FF sync, oversample tick, majority vote, optional parity.
// Latency: char/errors pulse one cycle after the stop-bit vote; no backpressure (line is free-running).
module uart_rx_char #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] char_dat,
  output logic                 char_vld,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 start_det,
  output logic                 idle_bit
);
  import uart_pkg::*;

  localparam int DIV     = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam bit HAS_PAR = (PARITY != int'(PAR_NONE));
  localparam bit ODD_PAR = (PARITY == int'(PAR_ODD));

  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

  logic                 sync1, sync2, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic                 tick, restart;
  logic                 at_v0, at_v1, at_v2, at_end;
  logic                 v0, v1, vote;

  rx_state_e            state, state_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 par_ok;
  logic                 char_vld_n, frame_err_n, parity_err_n;

  assign tick    = (div_cnt == DW'(DIV - 1));
  assign at_v0   = tick && (samp_cnt == S_V0);
  assign at_v1   = tick && (samp_cnt == S_V1);
  assign at_v2   = tick && (samp_cnt == S_V2);
  assign at_end  = tick && (samp_cnt == S_END);
  assign vote    = maj3(v0, v1, sync2);
  assign restart = (state == IDLE) && rx_prev && !sync2;
  assign par_ok  = ((^shreg) ^ par_bit) == ODD_PAR;

  assign char_dat  = shreg;
  assign start_det = restart;
  // Bit-time strobe while idle, used by the parent's partial-block timeout.
  assign idle_bit  = (state == IDLE) && at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      div_cnt  <= '0;
      samp_cnt <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
      if (restart) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + SW'(1);
      end
      if (at_v0) v0 <= sync2;
      if (at_v1) v1 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      char_vld   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      char_vld   <= char_vld_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    char_vld_n   = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (restart) state_n = START;
      end
      START: begin
        if (at_v1 && sync2) begin
          state_n = IDLE;
        end else if (at_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (at_v2) shreg_n = {vote, shreg[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_idx == BW'(DATA_BITS - 1)) state_n = HAS_PAR ? uart_pkg::PARITY : STOP;
          else bit_idx_n = bit_idx + BW'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (at_v2) par_bit_n = vote;
        if (at_end) state_n = STOP;
      end
      STOP: begin
        // Decide at the mid-bit vote so the next start edge is never missed.
        if (at_v2) begin
          frame_err_n  = !vote;
          parity_err_n = HAS_PAR && !par_ok;
          char_vld_n   = vote && !(HAS_PAR && !par_ok);
          state_n      = vote ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (sync2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_block_rx.sv
// UART receiver assembling BLOCK_BYTES chars into one block, with one-block skid and idle timeout.
// Latency: block_valid one cycle after the last char; backpressure: output + skid held, third block dropped.
module uart_block_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int BLOCK_BYTES  = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rxd_data_in,
  uart_block_rx_if.master                  blk,
  output logic [$clog2(BLOCK_BYTES+1)-1:0] byte_count,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overrun,
  output logic                             timeout_err
);
  import uart_pkg::*;

  localparam int W  = BLOCK_BYTES * DATA_BITS;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int IW = $clog2(TIMEOUT_BITS + 1);

  logic [DATA_BITS-1:0] char_dat;
  logic                 char_vld, start_det, idle_bit;

  logic [W-1:0]  asm_reg, asm_n, new_blk;
  logic [CW-1:0] bc_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [W-1:0]  out_reg, out_n, skid_reg, skid_n;
  logic          out_vld, out_vld_n, skid_vld, skid_vld_n;
  logic          overrun_n, timeout_n, accept, blk_done;

  uart_rx_char #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY)
  ) u_char (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd_data_in),
    .char_dat   (char_dat),
    .char_vld   (char_vld),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .start_det  (start_det),
    .idle_bit   (idle_bit)
  );

  assign blk.block_out   = out_reg;
  assign blk.block_valid = out_vld;
  assign accept          = out_vld && blk.block_ready;
  // Earlier chars shift toward the MS end, so the first char lands in the top slot.
  assign new_blk         = W'({asm_reg, char_dat});

  always_comb begin
    asm_n      = asm_reg;
    bc_n       = byte_count;
    idle_n     = idle_cnt;
    out_n      = out_reg;
    out_vld_n  = out_vld;
    skid_n     = skid_reg;
    skid_vld_n = skid_vld;
    overrun_n  = 1'b0;
    timeout_n  = 1'b0;
    blk_done   = 1'b0;

    if (accept) begin
      if (skid_vld) begin
        out_n      = skid_reg;
        skid_vld_n = 1'b0;
      end else begin
        out_vld_n = 1'b0;
      end
    end

    if (char_vld) begin
      asm_n = new_blk;
      if (byte_count == CW'(BLOCK_BYTES - 1)) begin
        blk_done = 1'b1;
        bc_n     = '0;
      end else begin
        bc_n = byte_count + CW'(1);
      end
    end

    if (blk_done) begin
      if (!out_vld_n) begin
        out_n     = new_blk;
        out_vld_n = 1'b1;
      end else if (!skid_vld_n) begin
        skid_n     = new_blk;
        skid_vld_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end

    if (start_det) begin
      idle_n = '0;
    end else if (idle_bit && (byte_count != '0)) begin
      if (idle_cnt == IW'(TIMEOUT_BITS - 1)) begin
        timeout_n = 1'b1;
        bc_n      = '0;
        idle_n    = '0;
      end else begin
        idle_n = idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_reg     <= '0;
      byte_count  <= '0;
      idle_cnt    <= '0;
      out_reg     <= '0;
      out_vld     <= 1'b0;
      skid_reg    <= '0;
      skid_vld    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      asm_reg     <= asm_n;
      byte_count  <= bc_n;
      idle_cnt    <= idle_n;
      out_reg     <= out_n;
      out_vld     <= out_vld_n;
      skid_reg    <= skid_n;
      skid_vld    <= skid_vld_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx: two instances (no parity / even parity) at 32 clk per bit.
module tb_uart_block_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 32;
  localparam logic [63:0] BLK1 = 64'h0102030405060708;
  localparam logic [63:0] BLK2 = 64'h090A0B0C0D0E0F10;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic [3:0] bc_a, bc_b;
  logic fe_a, pe_a, ov_a, to_a;
  logic fe_b, pe_b, ov_b, to_b;

  uart_block_rx_if #(.WIDTH(64)) ifa ();
  uart_block_rx_if #(.WIDTH(64)) ifb ();

  always #5 clk = ~clk;

  uart_block_rx #(
    .CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .BLOCK_BYTES(8), .TIMEOUT_BITS(20)
  ) u_a (
    .clk(clk), .rst(rst), .rxd_data_in(rxd_a), .blk(ifa), .byte_count(bc_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .timeout_err(to_a)
  );

  uart_block_rx #(
    .CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .BLOCK_BYTES(8), .TIMEOUT_BITS(20)
  ) u_b (
    .clk(clk), .rst(rst), .rxd_data_in(rxd_b), .blk(ifb), .byte_count(bc_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .timeout_err(to_b)
  );

  logic [63:0] acc_q[$];
  int n_vcyc_a = 0, n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_to_a = 0;
  int n_fe_b = 0, n_pe_b = 0, n_both_b = 0;
  int n_cmp = 0, n_bad = 0;
  int s_q, s_v, s_fe, s_pe, s_ov, s_to, s_err, s_both;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.block_valid && ifa.block_ready) acc_q.push_back(ifa.block_out);
      if (ifa.block_valid) n_vcyc_a++;
      if (fe_a) n_fe_a++;
      if (pe_a) n_pe_a++;
      if (ov_a) n_ov_a++;
      if (to_a) n_to_a++;
      if (fe_b) n_fe_b++;
      if (pe_b) n_pe_b++;
      if (fe_b && pe_b) n_both_b++;
    end
  end

  function automatic int err_a();
    return n_fe_a + n_pe_a + n_ov_a + n_to_a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_q    = acc_q.size();
    s_v    = n_vcyc_a;
    s_fe   = n_fe_a;
    s_pe   = n_pe_a;
    s_ov   = n_ov_a;
    s_to   = n_to_a;
    s_err  = err_a();
    s_both = n_both_b;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop_b);
    rxd_a = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd_a = d[i];
      wait_bits(1);
    end
    rxd_a = stop_b;
    wait_bits(1);
    rxd_a = 1'b1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic par, input logic stop_b);
    rxd_b = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd_b = d[i];
      wait_bits(1);
    end
    rxd_b = par;
    wait_bits(1);
    rxd_b = stop_b;
    wait_bits(1);
    rxd_b = 1'b1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    ifa.block_ready = 1'b1;
    ifb.block_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(ifa.block_valid), 64'd0);
    chk("rst_out", ifa.block_out, 64'd0);
    chk("rst_bc", 64'(bc_a), 64'd0);
    chk("rst_errs", 64'({fe_a, pe_a, ov_a, to_a}), 64'd0);
    wait_bits(2);

    // Full block, ready held high
    snap();
    send_a(8'h01, 1'b1);
    chk("bc_after1", 64'(bc_a), 64'd1);
    for (int i = 2; i <= 8; i++) send_a(8'(i), 1'b1);
    wait_bits(1);
    chk("blk_cnt", 64'(acc_q.size() - s_q), 64'd1);
    if (acc_q.size() > s_q) chk("blk_data", acc_q[s_q], BLK1);
    chk("blk_vcyc", 64'(n_vcyc_a - s_v), 64'd1);
    chk("blk_errs", 64'(err_a() - s_err), 64'd0);
    chk("blk_bc", 64'(bc_a), 64'd0);
    chk("blk_out_hold", ifa.block_out, BLK1);

    // Short low glitch on idle line
    snap();
    rxd_a = 1'b0;
    repeat (4) @(negedge clk);
    rxd_a = 1'b1;
    wait_bits(2);
    chk("glitch_state", 64'(u_a.u_char.state), 64'(IDLE));
    chk("glitch_bc", 64'(bc_a), 64'd0);
    chk("glitch_errs", 64'(err_a() - s_err), 64'd0);

    // Stop bit low, then a good char
    snap();
    send_a(8'h55, 1'b0);
    wait_bits(1);
    chk("ferr_cnt", 64'(n_fe_a - s_fe), 64'd1);
    chk("ferr_no_perr", 64'(n_pe_a - s_pe), 64'd0);
    chk("ferr_bc", 64'(bc_a), 64'd0);
    send_a(8'h11, 1'b1);
    chk("ferr_next_bc", 64'(bc_a), 64'd1);

    // Partial block timeout
    send_a(8'h22, 1'b1);
    send_a(8'h33, 1'b1);
    chk("tmo_bc3", 64'(bc_a), 64'd3);
    snap();
    wait_bits(18);
    chk("tmo_early", 64'(n_to_a - s_to), 64'd0);
    chk("tmo_bc_hold", 64'(bc_a), 64'd3);
    wait_bits(2);
    chk("tmo_pulse", 64'(n_to_a - s_to), 64'd1);
    chk("tmo_bc0", 64'(bc_a), 64'd0);

    // Even parity instance
    snap();
    send_b(8'h03, 1'b1, 1'b1);
    chk("par_err", 64'(n_pe_b), 64'd1);
    chk("par_no_ferr", 64'(n_fe_b), 64'd0);
    chk("par_bc", 64'(bc_b), 64'd0);
    send_b(8'h03, 1'b0, 1'b1);
    chk("par_ok_bc", 64'(bc_b), 64'd1);
    send_b(8'h03, 1'b1, 1'b0);
    wait_bits(1);
    chk("both_cnt", 64'(n_both_b - s_both), 64'd1);
    chk("both_fe", 64'(n_fe_b), 64'd1);
    chk("both_bc", 64'(bc_b), 64'd1);

    // Backpressure: 24 chars with ready low
    @(posedge clk);
    #1 ifa.block_ready = 1'b0;
    snap();
    for (int i = 0; i < 16; i++) send_a(8'(i + 1), 1'b1);
    chk("ovr_valid", 64'(ifa.block_valid), 64'd1);
    chk("ovr_out1", ifa.block_out, BLK1);
    chk("ovr_none_yet", 64'(n_ov_a - s_ov), 64'd0);
    for (int i = 16; i < 24; i++) send_a(8'(i + 1), 1'b1);
    chk("ovr_pulse", 64'(n_ov_a - s_ov), 64'd1);
    chk("ovr_out_hold", ifa.block_out, BLK1);
    chk("ovr_bc", 64'(bc_a), 64'd0);
    chk("ovr_no_xfer", 64'(acc_q.size() - s_q), 64'd0);
    @(posedge clk);
    #1 ifa.block_ready = 1'b1;
    wait_bits(1);
    chk("drain_cnt", 64'(acc_q.size() - s_q), 64'd2);
    if (acc_q.size() >= s_q + 2) begin
      chk("drain_b1", acc_q[s_q], BLK1);
      chk("drain_b2", acc_q[s_q+1], BLK2);
    end
    chk("drain_valid", 64'(ifa.block_valid), 64'd0);

    // Reset in the middle of a partial block and character
    send_a(8'hB1, 1'b1);
    send_a(8'hB2, 1'b1);
    chk("pre_rst_bc", 64'(bc_a), 64'd2);
    rxd_a = 1'b0;
    wait_bits(4);
    @(posedge clk);
    #1 rst = 1'b1;
    rxd_a = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_bc", 64'(bc_a), 64'd0);
    chk("mrst_valid", 64'(ifa.block_valid), 64'd0);
    chk("mrst_out", ifa.block_out, 64'd0);
    chk("mrst_state", 64'(u_a.u_char.state), 64'(IDLE));
    wait_bits(2);
    snap();
    for (int i = 0; i < 8; i++) send_a(8'hA1 + 8'(i), 1'b1);
    wait_bits(1);
    chk("post_rst_cnt", 64'(acc_q.size() - s_q), 64'd1);
    if (acc_q.size() > s_q) chk("post_rst_blk", acc_q[s_q], 64'hA1A2A3A4A5A6A7A8);
    chk("post_rst_errs", 64'(err_a() - s_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
